// File: rtl/arb_client_port.sv
`default_nettype none
// ============================================================================
//  Module   : arb_client_port
//  Purpose  : Requester-side adapter between a drawing-engine core and the
//             shared memory arbiter. Buffers core requests, offers them to
//             the arbiter with an rts/rtr handshake, limits the number of
//             outstanding reads so that returned data always has room, and
//             collects read data from the broadcast bus into an in-order
//             valid/ready response queue.
//  Ports    :
//    clk, rst_            clock, synchronous active-low reset
//    req_valid/req_ready  core request handshake
//    req_we/addr/wrdata   request payload (1 = write, 0 = read)
//    arb_rts/arb_rtr      arbiter handshake (transfer when both high)
//    arb_addr/wrdata/op   head request presented to the arbiter
//    bcast_data/xfc       shared read-return bus and per-client strobes
//    rsp_valid/ready/data read-data response queue to the core
//    busy                 any request, in-flight read or response pending
//    err_stray            sticky: a strobe arrived with no read outstanding
//  Revision : 1.0  initial release
// ============================================================================
module arb_client_port #(
  parameter int CLIENT_ID = 1,
  parameter int XFC_W     = 5,
  parameter int REQ_DEPTH = 4,
  parameter int RSP_DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_,
  // core request side
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             req_we,
  input  logic [16:0]      req_addr,
  input  logic [31:0]      req_wrdata,
  // arbiter side
  output logic             arb_rts,
  input  logic             arb_rtr,
  output logic [16:0]      arb_addr,
  output logic [31:0]      arb_wrdata,
  output logic [3:0]       arb_op,
  // broadcast read-return bus
  input  logic [31:0]      bcast_data,
  input  logic [XFC_W-1:0] bcast_xfc,
  // core response side
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [31:0]      rsp_data,
  // status
  output logic             busy,
  output logic             err_stray
);

  localparam int REQ_AW = $clog2(REQ_DEPTH);
  localparam int RSP_AW = $clog2(RSP_DEPTH);
  // Counters must hold the value RSP_DEPTH itself, hence one extra bit.
  localparam int CNT_W  = RSP_AW + 1;

  localparam logic [REQ_AW:0]  REQ_PTR_ONE = (REQ_AW+1)'(1);
  localparam logic [RSP_AW:0]  RSP_PTR_ONE = (RSP_AW+1)'(1);
  localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO    = '0;
  localparam logic [CNT_W:0]   CREDIT_LIM  = (CNT_W+1)'(RSP_DEPTH);

  // --------------------------------------------------------------------------
  // Request FIFO
  // --------------------------------------------------------------------------
  logic              req_we_mem   [REQ_DEPTH];
  logic [16:0]       req_addr_mem [REQ_DEPTH];
  logic [31:0]       req_data_mem [REQ_DEPTH];
  logic [REQ_AW:0]   req_wr_ptr;
  logic [REQ_AW:0]   req_rd_ptr;
  logic              req_empty;
  logic              req_full;
  logic              req_push;
  logic              head_we;
  logic [16:0]       head_addr;
  logic [31:0]       head_data;

  // Extra pointer bit distinguishes full (MSBs differ) from empty (equal).
  assign req_empty = (req_wr_ptr == req_rd_ptr);
  assign req_full  = (req_wr_ptr[REQ_AW] != req_rd_ptr[REQ_AW]) &&
                     (req_wr_ptr[REQ_AW-1:0] == req_rd_ptr[REQ_AW-1:0]);

  // req_ready comes straight from the registered pointers, so a pop in the
  // same cycle never opens a slot for a simultaneous push.
  assign req_ready = !req_full;
  assign req_push  = req_valid && req_ready;

  assign head_we   = req_we_mem  [req_rd_ptr[REQ_AW-1:0]];
  assign head_addr = req_addr_mem[req_rd_ptr[REQ_AW-1:0]];
  assign head_data = req_data_mem[req_rd_ptr[REQ_AW-1:0]];

  // Storage needs no reset: every output derived from it is gated by the
  // empty flag.
  always_ff @(posedge clk) begin
    if (req_push) begin
      req_we_mem  [req_wr_ptr[REQ_AW-1:0]] <= req_we;
      req_addr_mem[req_wr_ptr[REQ_AW-1:0]] <= req_addr;
      req_data_mem[req_wr_ptr[REQ_AW-1:0]] <= req_wrdata;
    end
  end

  // --------------------------------------------------------------------------
  // Response FIFO
  // --------------------------------------------------------------------------
  logic [31:0]       rsp_mem [RSP_DEPTH];
  logic [RSP_AW:0]   rsp_wr_ptr;
  logic [RSP_AW:0]   rsp_rd_ptr;
  logic              rsp_empty;
  logic [CNT_W-1:0]  rsp_count;
  logic              rsp_push;
  logic              rsp_pop;

  assign rsp_empty = (rsp_wr_ptr == rsp_rd_ptr);
  // Pointer difference modulo 2*depth is the occupancy (0..RSP_DEPTH).
  assign rsp_count = rsp_wr_ptr - rsp_rd_ptr;
  assign rsp_valid = !rsp_empty;
  assign rsp_pop   = rsp_valid && rsp_ready;
  assign rsp_data  = rsp_empty ? 32'h0 : rsp_mem[rsp_rd_ptr[RSP_AW-1:0]];

  always_ff @(posedge clk) begin
    if (rsp_push) begin
      rsp_mem[rsp_wr_ptr[RSP_AW-1:0]] <= bcast_data;
    end
  end

  // --------------------------------------------------------------------------
  // Issue / credit logic
  // --------------------------------------------------------------------------
  logic [CNT_W-1:0]  rd_out;
  logic [CNT_W:0]    credit_sum;
  logic              credit_ok;
  logic              xfc;
  logic              rd_xfc;
  logic              ret;
  logic              ret_ok;
  logic              unused_xfc;

  // Every issued read plus every buffered response owns one response slot,
  // so a return can always be stored.
  assign credit_sum = {1'b0, rd_out} + {1'b0, rsp_count};
  assign credit_ok  = (credit_sum < CREDIT_LIM);

  // Writes bypass the credit check, but only when they reach the head; a
  // write queued behind a blocked read waits to keep ordering.
  assign arb_rts    = !req_empty && (head_we || credit_ok);
  assign xfc        = arb_rts && arb_rtr;
  assign rd_xfc     = xfc && !head_we;

  assign arb_addr   = req_empty              ? 17'h0 : head_addr;
  assign arb_wrdata = (!req_empty && head_we) ? head_data : 32'h0;
  assign arb_op     = (!req_empty && head_we) ? 4'b1111 : 4'b0000;

  assign ret        = bcast_xfc[CLIENT_ID];
  assign ret_ok     = ret && (rd_out != CNT_ZERO);
  assign rsp_push   = ret_ok;

  // Strobes for other clients are intentionally ignored.
  assign unused_xfc = ^bcast_xfc;

  // --------------------------------------------------------------------------
  // State registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_) begin
      req_wr_ptr <= '0;
      req_rd_ptr <= '0;
      rsp_wr_ptr <= '0;
      rsp_rd_ptr <= '0;
      rd_out     <= '0;
      err_stray  <= 1'b0;
    end else begin
      if (req_push) begin
        req_wr_ptr <= req_wr_ptr + REQ_PTR_ONE;
      end
      if (xfc) begin
        req_rd_ptr <= req_rd_ptr + REQ_PTR_ONE;
      end
      if (rsp_push) begin
        rsp_wr_ptr <= rsp_wr_ptr + RSP_PTR_ONE;
      end
      if (rsp_pop) begin
        rsp_rd_ptr <= rsp_rd_ptr + RSP_PTR_ONE;
      end
      // A read issue and an accepted return in the same cycle cancel out.
      case ({rd_xfc, ret_ok})
        2'b10:   rd_out <= rd_out + CNT_ONE;
        2'b01:   rd_out <= rd_out - CNT_ONE;
        default: rd_out <= rd_out;
      endcase
      if (ret && !ret_ok) begin
        err_stray <= 1'b1;
      end
    end
  end

  assign busy = !req_empty || (rd_out != CNT_ZERO) || rsp_valid;

endmodule
`default_nettype wire

// File: tb/tb_arb_client_port.sv
`default_nettype none
// ============================================================================
//  Module   : tb_arb_client_port
//  Purpose  : Self-checking bench for arb_client_port. A reference model of
//             the request queue, outstanding-read count and response queue
//             predicts handshakes; expected requests and read data are kept
//             in scoreboard queues and compared when the DUT presents them.
//  Revision : 1.0  initial release
// ============================================================================
module tb_arb_client_port;

  localparam int CLIENT_ID = 1;
  localparam int XFC_W     = 5;
  localparam int REQ_DEPTH = 4;
  localparam int RSP_DEPTH = 4;

  logic             clk = 1'b0;
  logic             rst_;
  logic             req_valid;
  logic             req_ready;
  logic             req_we;
  logic [16:0]      req_addr;
  logic [31:0]      req_wrdata;
  logic             arb_rts;
  logic             arb_rtr;
  logic [16:0]      arb_addr;
  logic [31:0]      arb_wrdata;
  logic [3:0]       arb_op;
  logic [31:0]      bcast_data;
  logic [XFC_W-1:0] bcast_xfc;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [31:0]      rsp_data;
  logic             busy;
  logic             err_stray;

  always #5 clk = ~clk;

  arb_client_port #(
    .CLIENT_ID (CLIENT_ID),
    .XFC_W     (XFC_W),
    .REQ_DEPTH (REQ_DEPTH),
    .RSP_DEPTH (RSP_DEPTH)
  ) dut (
    .clk        (clk),
    .rst_       (rst_),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_addr   (req_addr),
    .req_wrdata (req_wrdata),
    .arb_rts    (arb_rts),
    .arb_rtr    (arb_rtr),
    .arb_addr   (arb_addr),
    .arb_wrdata (arb_wrdata),
    .arb_op     (arb_op),
    .bcast_data (bcast_data),
    .bcast_xfc  (bcast_xfc),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_data   (rsp_data),
    .busy       (busy),
    .err_stray  (err_stray)
  );

  typedef struct packed {
    logic        we;
    logic [16:0] addr;
    logic [31:0] data;
  } req_t;

  req_t        exp_req[$];   // model of the request FIFO
  logic [31:0] exp_rsp[$];   // model of the response FIFO
  int          ret_due[$];   // cycle numbers at which returns are driven
  int          m_rd_out;
  logic        m_err;
  int          cyc;
  bit          auto_ret;
  bit          pushed;
  int          n_ret;
  int          n_vec;
  int          n_err;

  task automatic check_val(input string tag, input logic [31:0] obs,
                           input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // One clock cycle: sample and model the cycle, take the edge, then drive
  // the arbiter-side read returns for the new cycle.
  task automatic tick();
    bit   exp_rts;
    bit   do_push;
    int   old_rd;
    req_t head;
    req_t nreq;
    #4;
    pushed = 1'b0;
    if (rst_ == 1'b0) begin
      @(posedge clk);
      cyc++;
      exp_req.delete();
      exp_rsp.delete();
      m_rd_out = 0;
      m_err    = 1'b0;
    end else begin
      exp_rts = (exp_req.size() > 0) &&
                (exp_req[0].we || ((m_rd_out + exp_rsp.size()) < RSP_DEPTH));
      check_val("req_ready", req_ready, exp_req.size() < REQ_DEPTH);
      check_val("arb_rts",   arb_rts,   exp_rts);
      check_val("rsp_valid", rsp_valid, exp_rsp.size() > 0);
      check_val("busy",      busy, (exp_req.size() > 0) || (m_rd_out != 0) ||
                                   (exp_rsp.size() > 0));
      check_val("err_stray", err_stray, m_err);
      old_rd  = m_rd_out;
      do_push = req_valid && (exp_req.size() < REQ_DEPTH);
      if (exp_rts && arb_rtr) begin
        head = exp_req.pop_front();
        check_val("arb_addr",   arb_addr,   head.addr);
        check_val("arb_op",     arb_op,     head.we ? 4'b1111 : 4'b0000);
        check_val("arb_wrdata", arb_wrdata, head.we ? head.data : 32'h0);
        if (!head.we) begin
          m_rd_out++;
          ret_due.push_back(cyc + 3);
        end
      end
      if ((exp_rsp.size() > 0) && rsp_ready) begin
        check_val("rsp_data", rsp_data, exp_rsp.pop_front());
      end
      if (bcast_xfc[CLIENT_ID]) begin
        if (old_rd > 0) begin
          exp_rsp.push_back(bcast_data);
          m_rd_out--;
        end else begin
          m_err = 1'b1;
        end
      end
      if (do_push) begin
        nreq.we   = req_we;
        nreq.addr = req_addr;
        nreq.data = req_wrdata;
        exp_req.push_back(nreq);
        pushed = 1'b1;
      end
      @(posedge clk);
      cyc++;
    end
    #1;
    if (auto_ret) begin
      if ((ret_due.size() > 0) && (ret_due[0] == cyc)) begin
        void'(ret_due.pop_front());
        bcast_xfc  = XFC_W'(1) << CLIENT_ID;
        bcast_data = 32'h12345678 + 32'(n_ret) * 32'h01010101;
        n_ret++;
      end else begin
        bcast_xfc  = '0;
      end
    end
  endtask

  // Offer one request and hold it until the model says it was accepted.
  task automatic push_req(input logic we, input logic [16:0] addr,
                          input logic [31:0] data);
    int guard;
    req_valid  = 1'b1;
    req_we     = we;
    req_addr   = addr;
    req_wrdata = data;
    guard      = 0;
    do begin
      tick();
      guard++;
    end while (!pushed && guard < 20);
    req_valid  = 1'b0;
    check_val("push_accept", pushed, 1'b1);
  endtask

  task automatic check_reset_outputs();
    check_val("rst_req_ready",  req_ready,  1'b1);
    check_val("rst_arb_rts",    arb_rts,    1'b0);
    check_val("rst_arb_op",     arb_op,     4'h0);
    check_val("rst_arb_addr",   arb_addr,   17'h0);
    check_val("rst_arb_wrdata", arb_wrdata, 32'h0);
    check_val("rst_rsp_valid",  rsp_valid,  1'b0);
    check_val("rst_rsp_data",   rsp_data,   32'h0);
    check_val("rst_busy",       busy,       1'b0);
    check_val("rst_err_stray",  err_stray,  1'b0);
  endtask

  initial begin
    n_vec      = 0;
    n_err      = 0;
    cyc        = 0;
    n_ret      = 0;
    m_rd_out   = 0;
    m_err      = 1'b0;
    auto_ret   = 1'b1;
    rst_       = 1'b0;
    req_valid  = 1'b0;
    req_we     = 1'b0;
    req_addr   = '0;
    req_wrdata = '0;
    arb_rtr    = 1'b0;
    bcast_data = '0;
    bcast_xfc  = '0;
    rsp_ready  = 1'b0;

    // Reset state
    tick();
    tick();
    rst_ = 1'b1;
    check_reset_outputs();

    // Single write
    push_req(1'b1, 17'h00010, 32'hDEADBEEF);
    check_val("wr_rts",    arb_rts,    1'b1);
    check_val("wr_op",     arb_op,     4'b1111);
    check_val("wr_addr",   arb_addr,   17'h00010);
    check_val("wr_data",   arb_wrdata, 32'hDEADBEEF);
    arb_rtr = 1'b1;
    tick();
    arb_rtr = 1'b0;
    check_val("wr_busy_after", busy, 1'b0);
    check_val("wr_no_rsp", rsp_valid, 1'b0);

    // Single read, returned three edges after the transfer
    push_req(1'b0, 17'h1FFFF, 32'hFFFFFFFF);
    check_val("rd_op",     arb_op,     4'b0000);
    check_val("rd_wrdata", arb_wrdata, 32'h0);
    arb_rtr = 1'b1;
    tick();
    arb_rtr = 1'b0;
    repeat (4) tick();
    check_val("rd_rsp_valid", rsp_valid, 1'b1);
    check_val("rd_rsp_data",  rsp_data,  32'h12345678);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    check_val("rd_busy_after", busy, 1'b0);

    // Credit block: five reads, responses not consumed
    arb_rtr = 1'b1;
    for (int i = 0; i < 5; i++) begin
      push_req(1'b0, 17'(32'h100 + i), 32'h0);
    end
    repeat (10) tick();
    check_val("cr_blocked_rts", arb_rts,   1'b0);
    check_val("cr_rsp_valid",   rsp_valid, 1'b1);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    check_val("cr_released_rts", arb_rts, 1'b1);
    rsp_ready = 1'b1;
    repeat (12) tick();
    rsp_ready = 1'b0;
    arb_rtr   = 1'b0;
    check_val("cr_drained_busy", busy, 1'b0);

    // Full request FIFO
    for (int i = 0; i < REQ_DEPTH; i++) begin
      push_req(1'b1, 17'(32'h200 + i), $urandom);
    end
    check_val("full_ready", req_ready, 1'b0);
    req_valid  = 1'b1;
    req_we     = 1'b1;
    req_addr   = 17'h002FF;
    req_wrdata = 32'hBADBAD00;
    tick();
    req_valid  = 1'b0;
    check_val("full_ready_hold", req_ready, 1'b0);
    arb_rtr = 1'b1;
    tick();
    arb_rtr = 1'b0;
    check_val("full_ready_free", req_ready, 1'b1);
    arb_rtr = 1'b1;
    repeat (5) tick();
    arb_rtr = 1'b0;
    check_val("full_drained_busy", busy, 1'b0);

    // Stray return and foreign strobe bit
    auto_ret   = 1'b0;
    bcast_data = 32'hCAFEF00D;
    bcast_xfc  = 5'b00010;
    tick();
    bcast_xfc  = 5'b00000;
    check_val("stray_err",   err_stray, 1'b1);
    check_val("stray_nrsp",  rsp_valid, 1'b0);
    bcast_xfc  = 5'b00100;
    tick();
    bcast_xfc  = 5'b00000;
    check_val("foreign_nrsp", rsp_valid, 1'b0);
    check_val("foreign_busy", busy,      1'b0);

    // Reset mid-read: the late return becomes a stray
    rst_ = 1'b0;
    tick();
    rst_ = 1'b1;
    check_val("rst2_err_clear", err_stray, 1'b0);
    auto_ret = 1'b1;
    push_req(1'b0, 17'h0ABCD, 32'h0);
    arb_rtr = 1'b1;
    tick();
    arb_rtr = 1'b0;
    check_val("mid_busy", busy, 1'b1);
    rst_ = 1'b0;
    tick();
    rst_ = 1'b1;
    check_reset_outputs();
    repeat (4) tick();
    check_val("mid_err_stray", err_stray, 1'b1);
    check_val("mid_no_rsp",    rsp_valid, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/arb_client_port.md
# arb_client_port

Requester-side adapter placed inside each drawing engine: the engine core pushes pixel read and write requests, and this port presents them to the memory arbiter using the rts/rtr/op handshake. It then collects read data from the shared broadcast bus when this client's bcast_xfc bit fires. It buffers requests, limits outstanding reads so that returned data can never be dropped, and returns read data in order to the core through a valid/ready response queue.

## Interface
- CLIENT_ID, 1: index of this client's bit in bcast_xfc.
- XFC_W, 5: width of bcast_xfc.
- REQ_DEPTH, 4: request FIFO entries (power of 2, ≥2).
- RSP_DEPTH, 4: response FIFO entries (power of 2, ≥2); also the read-credit limit.

- clk  in  1  single clock; all state updates on the rising edge.
- rst_  in  1  synchronous, active-low reset.
- req_valid  in  1  core offers a request.
- req_ready  out  1  request FIFO not full.
- req_we  in  1  1 = write, 0 = read.
- req_addr  in  17  word address.
- req_wrdata  in  32  write data (ignored for reads).
- arb_rts  out  1  head request offered to the arbiter.
- arb_rtr  in  1  arbiter grant for this client.
- arb_addr  out  17  head address.
- arb_wrdata  out  32  head write data; 0 for reads.
- arb_op  out  4  4'b1111 for write, 4'b0000 for read.
- bcast_data  in  32  shared read-data bus.
- bcast_xfc  in  XFC_W  per-client read-return strobes.
- rsp_valid  out  1  response FIFO not empty.
- rsp_ready  in  1  core accepts the head response.
- rsp_data  out  32  head read data.
- busy  out  1  requests are queued, reads are in flight, or responses are pending.
- err_stray  out  1  sticky flag: a strobe arrived with no read outstanding.

## Operation
- **Request FIFO.** A push occurs when req_valid & req_ready. Each entry holds {we, addr, wrdata}.
- **Issue.** arb_rts = !req_empty & (head.we | credit_ok), where credit_ok = (rd_out + rsp_count) < RSP_DEPTH. The arb_addr, arb_wrdata, and arb_op outputs are driven combinationally from the head entry.
- **Transfer.** A transfer (xfc) occurs when arb_rts & arb_rtr at a clock edge. On xfc, the head entry is popped; if the entry is a read, rd_out increments.
- **Return.** When ret = bcast_xfc[CLIENT_ID] is high at an edge:
  - If rd_out > 0: write bcast_data into the response FIFO and decrement rd_out.
  - If rd_out = 0: set err_stray and discard the data.
- **Simultaneous events.**
  - Read xfc together with a return: rd_out stays unchanged.
  - Push into a full request FIFO is impossible (req_ready = 0).
  - Push and pop in the same cycle on a full FIFO: the pop frees an entry but req_ready is still the registered full flag, so no push is accepted that cycle.
  - Response push and pop in the same cycle: rsp_count stays unchanged.
- **Credit rule.** The credit rule guarantees the response FIFO never overflows. Writes are never credit-blocked, but ordering is preserved: a write behind a blocked read waits.
- **FIFO pointers.** Pointers wrap modulo depth; full/empty are determined by an extra pointer bit.
- **Status.** busy = !req_empty | (rd_out ≠ 0) | rsp_valid.

## Timing
- **Reset** (rst_ low at an edge): FIFOs empty, rd_out = 0, err_stray = 0. Resulting outputs: req_ready = 1, arb_rts = 0, arb_op = 0, arb_addr = 0, arb_wrdata = 0, rsp_valid = 0, rsp_data = 0, busy = 0. Reset mid-operation discards all queued requests, in-flight reads, and responses; returns arriving after reset set err_stray.
- **Issue latency.** A request pushed at edge N can be offered (arb_rts) in cycle N+1 and transferred at the first later edge with arb_rtr high.
- **Read return.** The arbiter returns read data 3 edges after xfc. The port does not depend on that latency; it relies only on returns arriving in issue order.
- **Response latency.** rsp_valid rises in the cycle after the return edge, and rsp_data is stable while rsp_valid & !rsp_ready.
- **Throughput.** One xfc per cycle is possible when arb_rtr is held high.
- **err_stray** clears only on reset.

## Test plan
- **Single write.** Push we=1, addr=0x00010, data=0xDEADBEEF, then arb_rtr=1 → one xfc with arb_op=1111 and those values; no response; busy drops the cycle after the xfc.
- **Single read.** Push read addr=0x1FFFF; grant; pulse bcast_xfc=5'b00010 with bcast_data=0x12345678 three edges later → rsp_valid=1 with rsp_data=0x12345678; busy=0 after rsp_ready.
- **Credit block.** RSP_DEPTH=4 and rsp_ready=0; issue 5 reads and return 4 → the 5th read holds arb_rts=0. Pop one response → arb_rts=1.
- **Full request FIFO.** Push 4 requests with arb_rtr=0 → req_ready=0 and a 5th push is ignored. Grant once → req_ready=1.
- **Stray return and foreign bit.** Strobe bcast_xfc=5'b00010 with no read outstanding → err_stray=1 and no response. Strobe 5'b00100 → no effect.
- **Reset mid-read.** Issue a read, assert rst_ low for one cycle before the return → all outputs at reset values. The return then sets err_stray and produces no response.
